// File: rtl/filter_dot_product.sv
// filter_dot_product: signed Q8.8 dot product of one filter's weights with
// an ELEMENTS-long element burst from the vector manager. Weights are
// prefetched into a local register file, products accumulate in Q16.16,
// and the rounded, saturated result is held under a valid/taken handshake.
// Build option: define RELU_OUTPUT_EN to clamp negative results to zero.
module filter_dot_product #(
  parameter int ELEMENTS     = 8,
  parameter int NUM_FILTERS  = 4,
  parameter int W_ADDR_WIDTH = 10
) (
  input  logic                    clock,
  input  logic                    clear,
  input  logic                    en,
  output logic                    busy,
  output logic [W_ADDR_WIDTH-1:0] weight_memory_address,
  output logic                    weight_memory_enable,
  input  logic [15:0]             weight_element,
  output logic                    m_element_requested,
  input  logic                    m_element_ready,
  input  logic [15:0]             m_element,
  output logic [15:0]             result,
  output logic                    result_valid,
  input  logic                    result_taken,
  output logic                    filters_done
);

  localparam int KW = $clog2(ELEMENTS + 1);
  localparam int JW = (ELEMENTS > 1) ? $clog2(ELEMENTS) : 1;
  localparam int FW = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD_W  = 3'd1;
  localparam logic [2:0] S_REQUEST = 3'd2;
  localparam logic [2:0] S_STREAM  = 3'd3;
  localparam logic [2:0] S_ROUND   = 3'd4;
  localparam logic [2:0] S_HOLD    = 3'd5;

  logic [2:0]          state;
  logic [KW-1:0]       k;
  logic [JW-1:0]       j;
  logic [FW-1:0]       filter_index;
  logic signed [15:0]  wreg [ELEMENTS];
  logic signed [34:0]  acc;

  logic signed [31:0]  product;
  logic signed [35:0]  rounded_sum;
  logic signed [35:0]  shifted;
  logic signed [15:0]  saturated;
  logic [15:0]         result_next;
  logic [W_ADDR_WIDTH-1:0] filter_base;
  logic                last_filter;

  // Status, memory strobe and one-cycle pulses decoded from the state
  always_comb begin
    busy                 = (state != S_IDLE);
    weight_memory_enable = (state == S_LOAD_W) && (k < KW'(ELEMENTS));
    filter_base          = W_ADDR_WIDTH'(filter_index) * W_ADDR_WIDTH'(ELEMENTS);
    weight_memory_address = weight_memory_enable ? (filter_base + W_ADDR_WIDTH'(k)) : '0;
    m_element_requested  = (state == S_REQUEST);
    last_filter          = (filter_index == FW'(NUM_FILTERS - 1));
    filters_done         = (state == S_HOLD) && result_taken && last_filter;
  end

  // Multiply, round half-up, saturate to Q8.8 and optionally clamp at zero
  always_comb begin
    product     = $signed(wreg[j]) * $signed(m_element);
    rounded_sum = {acc[34], acc} + 36'sd128;
    shifted     = rounded_sum >>> 8;
    if (shifted > 36'sd32767)
      saturated = 16'sh7FFF;
    else if (shifted < -36'sd32768)
      saturated = -16'sh8000;
    else
      saturated = shifted[15:0];
`ifdef RELU_OUTPUT_EN
    result_next = saturated[15] ? '0 : saturated;
`else
    result_next = saturated;
`endif
  end

  // Control FSM, weight prefetch, accumulation and result handshake
  always_ff @(posedge clock) begin
    if (clear) begin
      state        <= S_IDLE;
      k            <= '0;
      j            <= '0;
      filter_index <= '0;
      acc          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      for (int unsigned i = 0; i < ELEMENTS; i++) wreg[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (en) begin
            state <= S_LOAD_W;
            k     <= '0;
          end
        end
        S_LOAD_W: begin
          // Read data lags the address by one cycle, so slot k-1 lands now
          if (k != '0) wreg[JW'(k - 1'b1)] <= weight_element;
          if (k == KW'(ELEMENTS)) state <= S_REQUEST;
          else                    k     <= k + 1'b1;
        end
        S_REQUEST: begin
          acc   <= '0;
          j     <= '0;
          state <= S_STREAM;
        end
        S_STREAM: begin
          if (m_element_ready) begin
            acc <= acc + {{3{product[31]}}, product};
            if (j == JW'(ELEMENTS - 1)) state <= S_ROUND;
            else                        j     <= j + 1'b1;
          end
        end
        S_ROUND: begin
          result       <= result_next;
          result_valid <= 1'b1;
          state        <= S_HOLD;
        end
        S_HOLD: begin
          if (result_taken) begin
            result_valid <= 1'b0;
            state        <= S_IDLE;
            filter_index <= last_filter ? '0 : filter_index + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_filter_dot_product.sv
// Scoreboard bench for filter_dot_product: runs push hand-computed results
// into a queue, a negedge monitor pops and compares on each new result_valid
// and also checks weight addresses and the element-request pulse count.
module tb_filter_dot_product;

`ifdef RELU_OUTPUT_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        en = 1'b0;
  logic        busy;
  logic [9:0]  weight_memory_address;
  logic        weight_memory_enable;
  logic [15:0] weight_element = '0;
  logic        m_element_requested;
  logic        m_element_ready = 1'b0;
  logic [15:0] m_element = '0;
  logic [15:0] result;
  logic        result_valid;
  logic        result_taken = 1'b0;
  logic        filters_done;

  filter_dot_product #(.ELEMENTS(8), .NUM_FILTERS(4), .W_ADDR_WIDTH(10)) dut (
    .clock(clock), .clear(clear), .en(en), .busy(busy),
    .weight_memory_address(weight_memory_address),
    .weight_memory_enable(weight_memory_enable),
    .weight_element(weight_element),
    .m_element_requested(m_element_requested),
    .m_element_ready(m_element_ready), .m_element(m_element),
    .result(result), .result_valid(result_valid),
    .result_taken(result_taken), .filters_done(filters_done)
  );

  always #5 clock = ~clock;

  // Weight memory with one-cycle read latency
  logic [15:0] mem [0:1023];
  always @(posedge clock)
    if (weight_memory_enable) weight_element <= mem[weight_memory_address];

  int n_checks = 0;
  int n_fail = 0;
  logic [15:0] exp_q[$];
  int addr_base = 0;
  int addr_cnt = 0;
  int req_cnt = 0;
  int fidx = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: result scoreboard, hold stability, address sequence, request pulses
  logic prev_valid = 1'b0;
  logic [15:0] held_exp = '0;
  always @(negedge clock) begin
    if (result_valid && !prev_valid) begin
      if (exp_q.size() == 0) check("unexpected_result", 32'(result_valid), 32'd0);
      else begin
        held_exp = exp_q.pop_front();
        check("result", 32'(result), 32'(held_exp));
      end
    end else if (result_valid && prev_valid) begin
      check("result_stable", 32'(result), 32'(held_exp));
    end
    prev_valid = result_valid;
    if (weight_memory_enable) begin
      check("w_addr", 32'(weight_memory_address), 32'(addr_base + addr_cnt));
      addr_cnt++;
    end
    if (m_element_requested) req_cnt++;
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic wait_request;
    int waited = 0;
    while (!m_element_requested && waited < 40) begin tick; waited++; end
    check("request_seen", 32'(m_element_requested), 32'd1);
  endtask

  task automatic send_elements(input logic [15:0] e, input int n, input int gap_max);
    for (int i = 0; i < n; i++) begin
      repeat ((gap_max > 0) ? $urandom_range(0, gap_max) : 0) tick;
      m_element_ready = 1'b1;
      m_element = e;
      tick;
      m_element_ready = 1'b0;
    end
  endtask

  task automatic run(input logic [15:0] w, input logic [15:0] e, input int gap_max,
                     input bit spurious, input int take_delay, input bit en_in_hold,
                     input logic [15:0] exp);
    int base = fidx * 8;
    int waited = 0;
    for (int i = 0; i < 8; i++) mem[base + i] = w;
    exp_q.push_back(exp);
    addr_base = base;
    addr_cnt = 0;
    req_cnt = 0;
    en = 1'b1;
    tick;
    en = 1'b0;
    if (spurious) begin
      tick;
      m_element_ready = 1'b1;
      m_element = 16'h7FFF;
      tick;
      m_element_ready = 1'b0;
    end
    wait_request;
    tick;
    send_elements(e, 8, gap_max);
    while (!result_valid && waited < 40) begin tick; waited++; end
    check("valid_seen", 32'(result_valid), 32'd1);
    check("req_pulses", 32'(req_cnt), 32'd1);
    check("addr_count", 32'(addr_cnt), 32'd8);
    for (int i = 0; i < take_delay; i++) begin
      if (en_in_hold) en = 1'b1;
      tick;
    end
    en = 1'b0;
    check("valid_held", 32'(result_valid), 32'd1);
    result_taken = 1'b1;
    #1;
    check("filters_done", 32'(filters_done), (fidx == 3) ? 32'd1 : 32'd0);
    tick;
    result_taken = 1'b0;
    check("idle_busy", 32'(busy), 32'd0);
    check("valid_dropped", 32'(result_valid), 32'd0);
    check("done_pulse_end", 32'(filters_done), 32'd0);
    fidx = (fidx + 1) % 4;
  endtask

  task automatic pulse_clear;
    clear = 1'b1;
    tick;
    clear = 1'b0;
    fidx = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    clear = 1'b1;
    repeat (3) tick;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(result_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_wen", 32'(weight_memory_enable), 32'd0);
    check("rst_addr", 32'(weight_memory_address), 32'd0);
    check("rst_req", 32'(m_element_requested), 32'd0);
    check("rst_done", 32'(filters_done), 32'd0);
    clear = 1'b0;
    tick;

    // Basic patterns across all four filters
    run(16'h0100, 16'h0100, 0, 1'b0, 0, 1'b0, 16'h0800);
    run(16'h0100, 16'hFF00, 0, 1'b0, 2, 1'b0, RELU ? 16'h0000 : 16'hF800);
    run(16'h7FFF, 16'h7FFF, 0, 1'b0, 0, 1'b0, 16'h7FFF);
    run(16'h7FFF, 16'h8000, 0, 1'b0, 1, 1'b0, RELU ? 16'h0000 : 16'h8000);

    // Gapped readies plus a spurious ready during weight load
    run(16'h0100, 16'h0100, 3, 1'b1, 0, 1'b0, 16'h0800);

    // clear mid-stream discards the partial sum
    addr_base = 8;
    addr_cnt = 0;
    en = 1'b1;
    tick;
    en = 1'b0;
    wait_request;
    tick;
    send_elements(16'h0100, 3, 0);
    pulse_clear;
    check("clr_busy", 32'(busy), 32'd0);
    check("clr_valid", 32'(result_valid), 32'd0);
    check("clr_req", 32'(m_element_requested), 32'd0);
    repeat (2) tick;
    run(16'h0100, 16'h0100, 0, 1'b0, 0, 1'b0, 16'h0800);

    // Four delayed takes with en asserted during HOLD, then wrap to base 0
    pulse_clear;
    run(16'h0100, 16'h0100, 0, 1'b0, 5, 1'b1, 16'h0800);
    run(16'h0200, 16'h0100, 1, 1'b0, 5, 1'b1, 16'h1000);
    run(16'h0080, 16'h0100, 0, 1'b0, 5, 1'b1, 16'h0400);
    run(16'h0100, 16'hFF00, 2, 1'b0, 5, 1'b1, RELU ? 16'h0000 : 16'hF800);
    run(16'h0100, 16'h0100, 0, 1'b0, 0, 1'b0, 16'h0800);

    repeat (3) tick;
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/filter_dot_product.md
Name: filter_dot_product

Overview:
- Downstream consumer of the M-vector element stream; computes one signed fixed-point dot product per request.
- Prefetches one filter's 8 weights from weight memory, then pulses m_element_requested to the vector manager.
- Accumulates weight[k]*element[k] over the 8 returned elements, then rounds, saturates and presents one 16-bit result to the next stage.
- Holds the result under a valid/taken handshake and steps through NUM_FILTERS filters in turn.

Parameters:
- ELEMENTS, 8: elements per dot product; equals the vector manager's burst length.
- NUM_FILTERS, 4: number of filters; the filter index wraps after the last one.
- W_ADDR_WIDTH, 10: weight memory address width.

Ports:
- clock  input  1  single system clock, rising edge.
- clear  input  1  synchronous active-high reset.
- en  input  1  start one dot product; sampled only in IDLE.
- busy  output  1  high in every state except IDLE.
- weight_memory_address  output  W_ADDR_WIDTH  equals filter_index*ELEMENTS + k.
- weight_memory_enable  output  1  read strobe; data returns 1 cycle later.
- weight_element  input  16  signed Q8.8 weight read data.
- m_element_requested  output  1  1-cycle pulse to the vector manager.
- m_element_ready  input  1  element valid strobe.
- m_element  input  16  signed Q8.8 element.
- result  output  16  signed Q8.8 dot product.
- result_valid  output  1  result available; held until taken.
- result_taken  input  1  consumer acknowledge.
- filters_done  output  1  1-cycle pulse when the filter index wraps to 0.

Behaviour:
- Reset: on clear, all outputs go to 0. State goes to IDLE. filter_index, k, the accumulator and the weight register file are zeroed. clear wins over every other input in the same cycle, including mid-operation: the partial sum is discarded and no result is produced.
- IDLE: when en=1, go to LOAD_W with k=0. en is ignored in all other states.
- LOAD_W: one address per cycle for k=0..ELEMENTS-1, with weight_memory_enable=1.
  - weight_element is written to wreg[k-1] one cycle after each address.
  - The state lasts ELEMENTS+1 cycles. The enable is low in the final cycle. Then go to REQUEST.
- REQUEST: m_element_requested=1 for exactly one cycle. Clear acc and element count j. Go to STREAM.
- STREAM: on each m_element_ready=1, acc += sign-extend(wreg[j]*m_element) and j increments.
  - Product is a 32-bit signed Q16.16 value; acc is 35-bit signed.
  - After the ELEMENTS-th ready, go to ROUND.
  - Ready pulses may be back-to-back or gapped; there is no timeout.
  - m_element_ready outside STREAM is ignored.
  - last_element from the vector manager is not used; the element count is local.
- ROUND (1 cycle): r = (acc + 0x80) >>> 8 (arithmetic shift). Saturate r to [-32768, 32767] and register it into result. Set result_valid=1. Go to HOLD.
- HOLD: result and result_valid stay stable until result_taken=1. In that cycle:
  - result_valid drops next cycle and the state goes to IDLE.
  - filter_index increments; NUM_FILTERS-1 wraps to 0 and filters_done pulses that same cycle.
- result_taken outside HOLD is ignored.
- Latency from en to result_valid, with no upstream gaps: 1 + (ELEMENTS+1) + 1 + T_up + 1 cycles, where T_up is the cycles from m_element_requested to the last m_element_ready.

Optional Feature:
- RELU_OUTPUT_EN defined: the saturated value is clamped at 0 before registering (negative -> 0x0000).
- Not defined: the signed saturated value passes through unchanged.
- Handshake and timing are identical either way.

Test Plan:
- All weights 0x0100, elements 0x0100 x8 -> result=0x0800, result_valid held; weight addresses 0..7 seen in LOAD_W; exactly one m_element_requested pulse.
- Weights 0x0100, elements 0xFF00 x8 -> result=0xF800 without RELU_OUTPUT_EN; result=0x0000 with it.
- Weights 0x7FFF, elements 0x7FFF x8 -> result=0x7FFF (saturated). Weights 0x7FFF, elements 0x8000 -> result=0x8000.
- Ready pulses gapped by 0-3 random idle cycles, plus spurious ready while in LOAD_W -> same result as the back-to-back case; spurious pulses ignored.
- clear asserted after 3 ready pulses -> next cycle busy=0 and result_valid=0; a fresh run with the weights/elements of the first scenario -> 0x0800.
- 4 runs with result_taken delayed 5 cycles each -> result stable while held; en in HOLD ignored; address bases 0, 8, 16, 24; filters_done pulses on the 4th take; 5th run uses base 0.
